// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchroniser plus stability-qualified level FSM.
// Cleans a bouncy button level before it reaches the sequence FSM `a` input.
module input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic a_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Last count value before a qualified change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  // With a one-cycle window the qualifying states are skipped entirely.
  localparam bit SINGLE = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {
    ST_LO      = 2'd0,
    ST_QUAL_HI = 2'd1,
    ST_HI      = 2'd2,
    ST_QUAL_LO = 2'd3
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_a;
  logic             w_a_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_fall;
  logic             w_fall_nxt;

  // Metastability guard: only r_sync2 is used by the decision logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_LO;
      r_cnt   <= '0;
      r_a     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a     <= w_a_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Next-state: a change must hold for STABLE_CYCLES edges; any reversal restarts.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_LO: begin
        if (r_sync2) begin
          if (SINGLE) begin
            w_state_nxt = ST_HI;
            w_cnt_nxt   = '0;
            w_a_nxt     = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_QUAL_HI;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ST_QUAL_HI: begin
        if (!r_sync2) begin
          w_state_nxt = ST_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HI;
          w_cnt_nxt   = '0;
          w_a_nxt     = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (!r_sync2) begin
          if (SINGLE) begin
            w_state_nxt = ST_LO;
            w_cnt_nxt   = '0;
            w_a_nxt     = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_QUAL_LO;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ST_QUAL_LO: begin
        if (r_sync2) begin
          w_state_nxt = ST_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_LO;
          w_cnt_nxt   = '0;
          w_a_nxt     = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_LO;
        w_cnt_nxt   = '0;
        w_a_nxt     = 1'b0;
      end
    endcase
  end

  assign a_out = r_a;
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign busy  = (r_state == ST_QUAL_HI) || (r_state == ST_QUAL_LO);

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: run-length reference model plus directed timing checks.
module tb_input_debouncer;

  localparam int S = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn = 1'b0;
  logic a_out, rise, fall, busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  input_debouncer #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn),
    .a_out   (a_out),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference: delay input by two samples, accept a level once it has
  // differed from the output for S consecutive edges.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_a = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int   m_run = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_a = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_s2 != m_a) begin
        m_run++;
        if (m_run >= S) begin
          m_a = ~m_a;
          if (m_a) m_rise = 1'b1; else m_fall = 1'b1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_a_out", a_out, m_a);
      chk("model_rise",  rise,  m_rise);
      chk("model_fall",  fall,  m_fall);
      chk("model_busy",  busy,  (m_run != 0));
      chk("rise_fall_exclusive", rise & fall, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n_busy, n_fall, n_rise, n;
    logic pat [6];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
    pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;

    // Reset held: outputs stay low.
    reset = 1'b0;
    btn   = 1'b1;
    repeat (3) step();
    chk("reset_a_out", a_out, 1'b0);
    chk("reset_rise",  rise,  1'b0);
    chk("reset_busy",  busy,  1'b0);
    btn = 1'b0;
    reset = 1'b1;
    chk_en = 1'b1;

    // Idle low for 20 cycles.
    n_busy = 0; n_rise = 0;
    repeat (20) begin
      step();
      if (busy) n_busy++;
      if (rise || fall || a_out) n_rise++;
    end
    chk("idle_no_busy", (n_busy != 0), 1'b0);
    chk("idle_no_activity", (n_rise != 0), 1'b0);

    // Press: btn changes before edge E; busy from E+2, a_out/rise at E+5.
    btn = 1'b1;
    step();                                   // E
    chk("press_E_busy", busy, 1'b0);
    step();                                   // E+1
    chk("press_E1_busy", busy, 1'b0);
    step();                                   // E+2
    chk("press_E2_busy", busy, 1'b1);
    chk("press_E2_a", a_out, 1'b0);
    step(); step();                           // E+4
    chk("press_E4_a", a_out, 1'b0);
    step();                                   // E+5
    chk("press_E5_a", a_out, 1'b1);
    chk("press_E5_rise", rise, 1'b1);
    chk("press_E5_fall", fall, 1'b0);
    step();                                   // E+6
    chk("press_E6_rise", rise, 1'b0);
    chk("press_E6_a", a_out, 1'b1);
    chk("press_E6_busy", busy, 1'b0);
    repeat (3) step();

    // Two-cycle low glitch while high: rejected, busy for two cycles.
    n_busy = 0; n_fall = 0;
    for (int i = 0; i < 12; i++) begin
      btn = (i < 2) ? 1'b0 : 1'b1;
      step();
      if (busy) n_busy++;
      if (fall) n_fall++;
    end
    chk("glitch_a_held", a_out, 1'b1);
    chk("glitch_no_fall", (n_fall != 0), 1'b0);
    chk("glitch_busy2", (n_busy == 2), 1'b1);

    // Release, then bounce train followed by a steady high.
    btn = 1'b0;
    repeat (12) step();
    chk("release_a", a_out, 1'b0);
    n_rise = 0; n_fall = 0;
    for (int i = 0; i < 6; i++) begin
      btn = pat[i];
      step();
      if (rise) n_rise++;
      if (fall) n_fall++;
    end
    repeat (10) begin
      step();
      if (rise) n_rise++;
      if (fall) n_fall++;
    end
    chk("bounce_one_rise", (n_rise == 1), 1'b1);
    chk("bounce_no_fall", (n_fall == 0), 1'b1);
    chk("bounce_a", a_out, 1'b1);

    // Reset in the middle of qualification (count at 2).
    btn = 1'b0;
    repeat (12) step();
    btn = 1'b1;
    repeat (4) step();                        // E+3: counting, count 2
    chk("midq_busy_before", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midq_reset_a", a_out, 1'b0);
    chk("midq_reset_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (a_out !== 1'b1 && n < 20) begin
      step();
      n++;
      if (rise && n < 6) chk("midq_no_stale_rise", rise, 1'b0);
    end
    chk("midq_six_edges", (n == 6), 1'b1);
    repeat (3) step();

    // Random run-length stimulus with occasional resets.
    for (int k = 0; k < 400; k++) begin
      btn = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 299) == 0) begin
          #2 reset = 1'b0;
          @(negedge clk);
          reset = 1'b1;
        end else begin
          step();
        end
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
